// File: rtl/design_params_pkg.sv
// design_params_pkg: shared bus widths, the timer register map and the bus-master types.
// Used by timer_bus_master and anything else that talks to the timer peripheral.
package design_params_pkg;

    localparam int P_ADDR_WIDTH = 8;
    localparam int P_DATA_WIDTH = 32;

    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_CONTROL = 8'h00;
    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_LOAD    = 8'h04;
    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_STATUS  = 8'h08;
    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_COUNT   = 8'h0C;

    localparam int P_BIT_START = 0;
    localparam int P_BIT_DONE  = 0;

    typedef enum logic [1:0] {IDLE, REQ, GAP} mst_state_e;

    typedef struct packed {
        logic                    write;
        logic [P_ADDR_WIDTH-1:0] addr;
        logic [P_DATA_WIDTH-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/timer_bus_master.sv
// timer_bus_master: one-command-at-a-time initiator for the timer req/gnt register bus.
// Define TIMER_BUS_TIMEOUT_EN to abort a REQ with rsp_err after TIMEOUT_CYCLES without gnt.
module timer_bus_master
    import design_params_pkg::*;
#(
    parameter int ADDR_W         = P_ADDR_WIDTH,
    parameter int DATA_W         = P_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              write_en,
    input  logic [DATA_W-1:0] rdata
);

    mst_state_e state, state_nxt;
    bus_cmd_t   bus;
    logic       accept, done, tmo;

`ifdef TIMER_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign tmo = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = TIMEOUT_CYCLES < 0;
`endif

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_ready && cmd_valid;
    assign done      = state == REQ && (gnt || tmo);
    assign addr      = ADDR_W'(bus.addr);
    assign wdata     = DATA_W'(bus.wdata);
    assign write_en  = bus.write;

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = REQ;
        else if (done)
            state_nxt = GAP;
        else if (state == GAP)
            state_nxt = IDLE;
    end

    // A timeout only completes the REQ when gnt is absent, so gnt wins a tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bus       <= '0;
            req       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef TIMER_BUS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus     <= '{write: cmd_write, addr: P_ADDR_WIDTH'(cmd_addr), wdata: P_DATA_WIDTH'(cmd_wdata)};
                req     <= 1'b1;
                rsp_err <= 1'b0;
            end
            if (done) begin
                bus       <= '0;
                req       <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= !gnt;
                rsp_rdata <= (bus.write || !gnt) ? '0 : rdata;
            end
            if (state == GAP)
                rsp_valid <= 1'b0;
`ifdef TIMER_BUS_TIMEOUT_EN
            if (accept)
                wait_cnt <= '0;
            else if (state == REQ)
                wait_cnt <= wait_cnt + 8'd1;
`endif
        end
    end

endmodule
